// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scancode bytes -> game key levels, paddle command
// and edge pulses. Tracks E0 (extended) and F0 (break) prefixes with a timeout.
// Optional build macro: KEY_WASD_ALIAS_EN (A/D keys alias left/right arrows).
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear_keys,
  output logic       key_left,
  output logic       key_right,
  output logic       key_space,
  output logic [1:0] paddle_cmd,
  output logic       space_pulse,
  output logic       esc_pulse,
  output logic       proto_err
);

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_SPACE = 8'h29;
  localparam logic [7:0] B_ESC   = 8'h76;
  localparam logic [7:0] B_LEFT  = 8'h6B;
  localparam logic [7:0] B_RIGHT = 8'h74;
`ifdef KEY_WASD_ALIAS_EN
  localparam logic [7:0] B_KEY_A = 8'h1C;
  localparam logic [7:0] B_KEY_D = 8'h23;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             arrow_l_q, arrow_l_n;
  logic             arrow_r_q, arrow_r_n;
  logic             space_n;
  logic             esc_held_q, esc_held_n;
  logic             sp_pulse_n, esc_pulse_n, err_n;
  logic             left_n, right_n;
`ifdef KEY_WASD_ALIAS_EN
  logic             a_held_q, a_held_n;
  logic             d_held_q, d_held_n;
`endif

  // Next-state decode: one byte (or one idle cycle) per clock; key_space doubles as space-held state
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    arrow_l_n   = arrow_l_q;
    arrow_r_n   = arrow_r_q;
    space_n     = key_space;
    esc_held_n  = esc_held_q;
    sp_pulse_n  = 1'b0;
    esc_pulse_n = 1'b0;
    err_n       = 1'b0;
`ifdef KEY_WASD_ALIAS_EN
    a_held_n    = a_held_q;
    d_held_n    = d_held_q;
`endif
    if (clear_keys) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      arrow_l_n  = 1'b0;
      arrow_r_n  = 1'b0;
      space_n    = 1'b0;
      esc_held_n = 1'b0;
`ifdef KEY_WASD_ALIAS_EN
      a_held_n   = 1'b0;
      d_held_n   = 1'b0;
`endif
    end else if (rx_valid) begin
      cnt_n = '0;
      unique case (state_q)
        S_IDLE: begin
          case (rx_data)
            B_EXT:   state_n = S_EXT;
            B_BRK:   state_n = S_BRK;
            B_SPACE: begin
              sp_pulse_n = ~key_space;
              space_n    = 1'b1;
            end
            B_ESC: begin
              esc_pulse_n = ~esc_held_q;
              esc_held_n  = 1'b1;
            end
`ifdef KEY_WASD_ALIAS_EN
            B_KEY_A: a_held_n = 1'b1;
            B_KEY_D: d_held_n = 1'b1;
`endif
            default: ;
          endcase
        end
        S_EXT: begin
          case (rx_data)
            B_LEFT:  begin arrow_l_n = 1'b1; state_n = S_IDLE; end
            B_RIGHT: begin arrow_r_n = 1'b1; state_n = S_IDLE; end
            B_BRK:   state_n = S_EXT_BRK;
            B_EXT:   state_n = S_EXT;
            default: state_n = S_IDLE;
          endcase
        end
        S_BRK: begin
          case (rx_data)
            B_SPACE: begin space_n = 1'b0; state_n = S_IDLE; end
            B_ESC:   begin esc_held_n = 1'b0; state_n = S_IDLE; end
`ifdef KEY_WASD_ALIAS_EN
            B_KEY_A: begin a_held_n = 1'b0; state_n = S_IDLE; end
            B_KEY_D: begin d_held_n = 1'b0; state_n = S_IDLE; end
`endif
            B_BRK:   state_n = S_BRK;
            B_EXT:   state_n = S_EXT;
            default: state_n = S_IDLE;
          endcase
        end
        S_EXT_BRK: begin
          if (rx_data == B_LEFT)  arrow_l_n = 1'b0;
          if (rx_data == B_RIGHT) arrow_r_n = 1'b0;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // Abandon a dangling prefix; held levels are left untouched
      if (cnt_q == CNT_LAST) begin
        state_n = S_IDLE;
        cnt_n   = '0;
        err_n   = 1'b1;
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

`ifdef KEY_WASD_ALIAS_EN
  assign left_n  = arrow_l_n | a_held_n;
  assign right_n = arrow_r_n | d_held_n;
`else
  assign left_n  = arrow_l_n;
  assign right_n = arrow_r_n;
`endif

  // State and output registers; paddle_cmd is built from next levels so it lines up with key_left/key_right
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      arrow_l_q   <= 1'b0;
      arrow_r_q   <= 1'b0;
      esc_held_q  <= 1'b0;
`ifdef KEY_WASD_ALIAS_EN
      a_held_q    <= 1'b0;
      d_held_q    <= 1'b0;
`endif
      key_left    <= 1'b0;
      key_right   <= 1'b0;
      key_space   <= 1'b0;
      paddle_cmd  <= 2'b00;
      space_pulse <= 1'b0;
      esc_pulse   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      arrow_l_q   <= arrow_l_n;
      arrow_r_q   <= arrow_r_n;
      esc_held_q  <= esc_held_n;
`ifdef KEY_WASD_ALIAS_EN
      a_held_q    <= a_held_n;
      d_held_q    <= d_held_n;
`endif
      key_left    <= left_n;
      key_right   <= right_n;
      key_space   <= space_n;
      paddle_cmd  <= {left_n & ~right_n, right_n & ~left_n};
      space_pulse <= sp_pulse_n;
      esc_pulse   <= esc_pulse_n;
      proto_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: table of one-byte-per-cycle vectors checked
// through an expected-value queue, plus hand sequences for timeout and reset.
module tb_ps2_key_decoder;

  localparam int unsigned T = 16;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear_keys;
  logic       key_left, key_right, key_space;
  logic [1:0] paddle_cmd;
  logic       space_pulse, esc_pulse, proto_err;

  int checks = 0;
  int errors = 0;

  // packed outputs: {left, right, space, cmd[1:0], space_pulse, esc_pulse, proto_err}
  logic [7:0] outs;
  assign outs = {key_left, key_right, key_space, paddle_cmd, space_pulse, esc_pulse, proto_err};

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  ps2_key_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear_keys(clear_keys), .key_left(key_left), .key_right(key_right),
    .key_space(key_space), .paddle_cmd(paddle_cmd), .space_pulse(space_pulse),
    .esc_pulse(esc_pulse), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic c, input logic v, input logic [7:0] d, input logic [7:0] e);
    vec_t x;
    x.clr = c; x.vld = v; x.data = d; x.exp = e;
    vecs.push_back(x);
  endtask

  // Drive one cycle of input, queue its expectation, compare once the edge has registered it
  task automatic step(input logic c, input logic v, input logic [7:0] d, input logic [7:0] e,
                      input string nm);
    logic [7:0] ex;
    @(negedge clock);
    clear_keys = c; rx_valid = v; rx_data = d;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    ex = exp_q.pop_front();
    check(nm, {24'd0, outs}, {24'd0, ex});
    rx_valid = 1'b0; clear_keys = 1'b0; rx_data = 8'h00;
  endtask

  initial begin
    int first_k;
    int n_err;
    resetn = 1'b0; rx_valid = 1'b0; clear_keys = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {24'd0, outs}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // test 1: left arrow make / release
    add(0, 1, 8'hE0, 8'b00000000);
    add(0, 1, 8'h6B, 8'b10010000);
    add(0, 0, 8'h00, 8'b10010000);
    add(0, 1, 8'hE0, 8'b10010000);
    add(0, 1, 8'hF0, 8'b10010000);
    add(0, 1, 8'h6B, 8'b00000000);
    // test 2: typematic space
    add(0, 1, 8'h29, 8'b00100100);
    add(0, 1, 8'h29, 8'b00100000);
    add(0, 1, 8'h29, 8'b00100000);
    add(0, 1, 8'hF0, 8'b00100000);
    add(0, 1, 8'h29, 8'b00000000);
    // test 3: both arrows, then release left
    add(0, 1, 8'hE0, 8'b00000000);
    add(0, 1, 8'h6B, 8'b10010000);
    add(0, 1, 8'hE0, 8'b10010000);
    add(0, 1, 8'h74, 8'b11000000);
    add(0, 1, 8'hE0, 8'b11000000);
    add(0, 1, 8'hF0, 8'b11000000);
    add(0, 1, 8'h6B, 8'b01001000);
    // Esc typematic filter and fresh make after release
    add(0, 1, 8'h76, 8'b01001010);
    add(0, 1, 8'h76, 8'b01001000);
    add(0, 1, 8'hF0, 8'b01001000);
    add(0, 1, 8'h76, 8'b01001000);
    add(0, 1, 8'h76, 8'b01001010);
`ifdef KEY_WASD_ALIAS_EN
    add(0, 1, 8'h1C, 8'b11000000);
    add(0, 1, 8'hF0, 8'b11000000);
    add(0, 1, 8'h1C, 8'b01001000);
    add(0, 1, 8'hE0, 8'b01001000);
    add(0, 1, 8'h6B, 8'b11000000);
    add(0, 1, 8'h1C, 8'b11000000);
    add(0, 1, 8'hF0, 8'b11000000);
    add(0, 1, 8'h1C, 8'b11000000);
    add(0, 1, 8'hE0, 8'b11000000);
    add(0, 1, 8'hF0, 8'b11000000);
    add(0, 1, 8'h6B, 8'b01001000);
`else
    add(0, 1, 8'h1C, 8'b01001000);
    add(0, 1, 8'hF0, 8'b01001000);
    add(0, 1, 8'h1C, 8'b01001000);
`endif
    // unknown byte after E0 abandons prefix; bare 74 then ignored
    add(0, 1, 8'hE0, 8'b01001000);
    add(0, 1, 8'h12, 8'b01001000);
    add(0, 1, 8'h74, 8'b01001000);
    // clear_keys wins over same-cycle space byte
    add(1, 1, 8'h29, 8'b00000000);
    add(0, 0, 8'h00, 8'b00000000);
    // clear mid-prefix returns to IDLE, so 6B is ignored
    add(0, 1, 8'hE0, 8'b00000000);
    add(1, 0, 8'h00, 8'b00000000);
    add(0, 1, 8'h6B, 8'b00000000);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].clr, vecs[i].vld, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

    // test 4: prefix timeout with left held
    step(0, 1, 8'hE0, 8'b00000000, "to_e0a");
    step(0, 1, 8'h6B, 8'b10010000, "to_left");
    step(0, 1, 8'hE0, 8'b10010000, "to_e0b");
    first_k = 0; n_err = 0;
    for (int k = 1; k <= 3 * T; k++) begin
      @(posedge clock);
      #1;
      if (proto_err) begin
        n_err++;
        if (first_k == 0) first_k = k;
      end
    end
    check("timeout_cycle", first_k, T);
    check("timeout_pulses", n_err, 1);
    check("timeout_levels", {24'd0, outs}, {24'd0, 8'b10010000});
    step(0, 1, 8'h74, 8'b10010000, "after_to_74");

    // test 5: resetn mid E0,F0 sequence; trailing 6B is an orphan
    step(0, 1, 8'hE0, 8'b10010000, "rst_e0");
    step(0, 1, 8'hF0, 8'b10010000, "rst_f0");
    @(negedge clock);
    #2 resetn = 1'b0;
    #1 check("async_reset", {24'd0, outs}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    step(0, 1, 8'h6B, 8'b00000000, "orphan_6b");
    step(0, 1, 8'h29, 8'b00100100, "post_rst_space");

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
